// File: rtl/mib_pkg.sv
// Shared types for the MIB master hub and its helpers.
package mib_pkg;

    localparam int MIB_DATA_W = 16;

    typedef enum logic [1:0] {
        MIB_OK        = 2'b00,
        MIB_TIMEOUT   = 2'b01,
        MIB_COLLISION = 2'b10
    } mib_status_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_WAIT_ACK,
        ST_RDATA,
        ST_DONE
    } mib_state_e;

endpackage

// File: rtl/mib_ack_check.sv
// Ack vector qualifier: masks acks with the enable vector and flags
// "any ack" and "more than one ack" (collision). Purely combinational.
module mib_ack_check
    import mib_pkg::*;
#(
    parameter int P_NUM_SLAVES = 8
) (
    input  logic [P_NUM_SLAVES-1:0] i_ack,
    input  logic [P_NUM_SLAVES-1:0] i_en,
    output logic [P_NUM_SLAVES-1:0] o_masked,
    output logic                    o_any,
    output logic                    o_multi
);

    assign o_masked = i_ack & i_en;
    assign o_any    = |o_masked;
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign o_multi  = |(o_masked & (o_masked - P_NUM_SLAVES'(1)));

endmodule

// File: rtl/mib_master_hub.sv
// MIB bus master: serialises address/write data MS beat first, waits for a
// qualified slave ack (with timeout and collision detection), collects read
// data and reports the result on a one-cycle response strobe.
// Every output is a flop whose next value is derived from the next state, so
// bus outputs line up exactly with the state they belong to.
module mib_master_hub
    import mib_pkg::*;
#(
    parameter int P_NUM_SLAVES       = 8,
    parameter int P_DATA_W           = MIB_DATA_W,
    parameter int P_ADDR_BEATS       = 2,
    parameter int P_DATA_BEATS       = 2,
    parameter int P_ACK_TIMEOUT_CLKS = 64
) (
    input  logic                             CLK,
    input  logic                             i_srst,
    input  logic                             i_req_valid,
    output logic                             o_req_ready,
    input  logic                             i_req_rd_wr_n,
    input  logic [P_ADDR_BEATS*P_DATA_W-1:0] i_req_addr,
    input  logic [P_DATA_BEATS*P_DATA_W-1:0] i_req_wdata,
    input  logic [P_NUM_SLAVES-1:0]          i_slave_en,
    output logic                             o_mib_start,
    output logic                             o_mib_rd_wr_n,
    output logic [P_DATA_W-1:0]              o_dabus,
    output logic                             o_dabus_oe,
    input  logic [P_DATA_W-1:0]              i_dabus,
    input  logic [P_NUM_SLAVES-1:0]          i_mib_slave_ack,
    output logic                             o_rsp_valid,
    output logic [P_DATA_BEATS*P_DATA_W-1:0] o_rsp_rdata,
    output logic [1:0]                       o_rsp_status,
    output logic [P_NUM_SLAVES-1:0]          o_rsp_ack_mask
);

    localparam int AW        = P_ADDR_BEATS * P_DATA_W;
    localparam int DW        = P_DATA_BEATS * P_DATA_W;
    localparam int BEATS_MAX = (P_ADDR_BEATS > P_DATA_BEATS) ? P_ADDR_BEATS : P_DATA_BEATS;
    localparam int CNT_MAX   = (BEATS_MAX > P_ACK_TIMEOUT_CLKS) ? BEATS_MAX : P_ACK_TIMEOUT_CLKS;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    // State and transaction context
    mib_state_e              r_state,      w_state_next;
    logic [CNT_W-1:0]        r_cnt,        w_cnt_next;
    logic [AW-1:0]           r_addr,       w_addr_next;
    logic [DW-1:0]           r_wdata,      w_wdata_next;
    logic                    r_rd_wr_n,    w_rd_wr_n_next;
    logic [P_NUM_SLAVES-1:0] r_ack_cap,    w_ack_cap_next;
    logic [DW-1:0]           r_rdata_sh,   w_rdata_sh_next;

    // Registered outputs
    logic                    r_req_ready,    w_req_ready_next;
    logic                    r_mib_start,    w_mib_start_next;
    logic                    r_mib_rd_wr_n,  w_mib_rd_wr_n_next;
    logic [P_DATA_W-1:0]     r_dabus,        w_dabus_next;
    logic                    r_dabus_oe,     w_dabus_oe_next;
    logic                    r_rsp_valid,    w_rsp_valid_next;
    logic [DW-1:0]           r_rsp_rdata,    w_rsp_rdata_next;
    mib_status_e             r_rsp_status,   w_rsp_status_next;
    logic [P_NUM_SLAVES-1:0] r_rsp_ack_mask, w_rsp_ack_mask_next;

    logic [P_NUM_SLAVES-1:0] w_masked;
    logic                    w_any;
    logic                    w_multi;

    mib_ack_check #(
        .P_NUM_SLAVES (P_NUM_SLAVES)
    ) u_ack_check (
        .i_ack    (i_mib_slave_ack),
        .i_en     (i_slave_en),
        .o_masked (w_masked),
        .o_any    (w_any),
        .o_multi  (w_multi)
    );

    // Next-state, context and output computation
    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt;
        w_addr_next         = r_addr;
        w_wdata_next        = r_wdata;
        w_rd_wr_n_next      = r_rd_wr_n;
        w_ack_cap_next      = r_ack_cap;
        w_rdata_sh_next     = r_rdata_sh;
        w_rsp_rdata_next    = r_rsp_rdata;
        w_rsp_status_next   = r_rsp_status;
        w_rsp_ack_mask_next = r_rsp_ack_mask;
        w_mib_start_next    = 1'b0;
        w_dabus_next        = '0;
        w_dabus_oe_next     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_req_valid && r_req_ready) begin
                    w_addr_next    = i_req_addr;
                    w_wdata_next   = i_req_wdata;
                    w_rd_wr_n_next = i_req_rd_wr_n;
                    w_cnt_next     = '0;
                    w_state_next   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (r_cnt == CNT_W'(P_ADDR_BEATS - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = r_rd_wr_n ? ST_WAIT_ACK : ST_WDATA;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_WDATA: begin
                if (r_cnt == CNT_W'(P_DATA_BEATS - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_WAIT_ACK;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_WAIT_ACK: begin
                // An ack takes priority over the timeout, even on the final cycle.
                if (w_any) begin
                    w_ack_cap_next = w_masked;
                    if (w_multi) begin
                        w_rsp_status_next   = MIB_COLLISION;
                        w_rsp_rdata_next    = '0;
                        w_rsp_ack_mask_next = w_masked;
                        w_state_next        = ST_DONE;
                    end else if (!r_rd_wr_n) begin
                        w_rsp_status_next   = MIB_OK;
                        w_rsp_rdata_next    = '0;
                        w_rsp_ack_mask_next = w_masked;
                        w_state_next        = ST_DONE;
                    end else begin
                        w_cnt_next      = '0;
                        w_rdata_sh_next = '0;
                        w_state_next    = ST_RDATA;
                    end
                end else if (r_cnt == CNT_W'(P_ACK_TIMEOUT_CLKS - 1)) begin
                    w_rsp_status_next   = MIB_TIMEOUT;
                    w_rsp_rdata_next    = '0;
                    w_rsp_ack_mask_next = '0;
                    w_state_next        = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_RDATA: begin
                w_rdata_sh_next = (r_rdata_sh << P_DATA_W) | DW'(i_dabus);
                if (r_cnt == CNT_W'(P_DATA_BEATS - 1)) begin
                    w_rsp_status_next   = MIB_OK;
                    w_rsp_rdata_next    = w_rdata_sh_next;
                    w_rsp_ack_mask_next = r_ack_cap;
                    w_state_next        = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are valid with it.
        w_req_ready_next   = (w_state_next == ST_IDLE);
        w_rsp_valid_next   = (w_state_next == ST_DONE);
        w_mib_rd_wr_n_next = (w_state_next == ST_IDLE) ? 1'b1 : w_rd_wr_n_next;
        if (w_state_next == ST_ADDR) begin
            w_dabus_oe_next  = 1'b1;
            w_mib_start_next = (w_cnt_next == '0);
            w_dabus_next     = P_DATA_W'(w_addr_next >> ((P_ADDR_BEATS - 1 - int'(w_cnt_next)) * P_DATA_W));
        end else if (w_state_next == ST_WDATA) begin
            w_dabus_oe_next  = 1'b1;
            w_dabus_next     = P_DATA_W'(w_wdata_next >> ((P_DATA_BEATS - 1 - int'(w_cnt_next)) * P_DATA_W));
        end
    end

    // State, context and output registers; reset aborts any transaction at once
    always_ff @(posedge CLK) begin
        if (i_srst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_rd_wr_n      <= 1'b1;
            r_ack_cap      <= '0;
            r_rdata_sh     <= '0;
            r_req_ready    <= 1'b0;
            r_mib_start    <= 1'b0;
            r_mib_rd_wr_n  <= 1'b1;
            r_dabus        <= '0;
            r_dabus_oe     <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= '0;
            r_rsp_status   <= MIB_OK;
            r_rsp_ack_mask <= '0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_addr         <= w_addr_next;
            r_wdata        <= w_wdata_next;
            r_rd_wr_n      <= w_rd_wr_n_next;
            r_ack_cap      <= w_ack_cap_next;
            r_rdata_sh     <= w_rdata_sh_next;
            r_req_ready    <= w_req_ready_next;
            r_mib_start    <= w_mib_start_next;
            r_mib_rd_wr_n  <= w_mib_rd_wr_n_next;
            r_dabus        <= w_dabus_next;
            r_dabus_oe     <= w_dabus_oe_next;
            r_rsp_valid    <= w_rsp_valid_next;
            r_rsp_rdata    <= w_rsp_rdata_next;
            r_rsp_status   <= w_rsp_status_next;
            r_rsp_ack_mask <= w_rsp_ack_mask_next;
        end
    end

    assign o_req_ready    = r_req_ready;
    assign o_mib_start    = r_mib_start;
    assign o_mib_rd_wr_n  = r_mib_rd_wr_n;
    assign o_dabus        = r_dabus;
    assign o_dabus_oe     = r_dabus_oe;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_rdata    = r_rsp_rdata;
    assign o_rsp_status   = r_rsp_status;
    assign o_rsp_ack_mask = r_rsp_ack_mask;

endmodule

// File: tb/tb_mib_master_hub.sv
// Bench for mib_master_hub: table of transactions driven by a slave model,
// responses checked through a scoreboard queue, plus reset and back-to-back
// hand sequences.
module tb_mib_master_hub;

    logic        CLK = 1'b0;
    logic        i_srst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_rd_wr_n;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [7:0]  i_slave_en;
    logic        o_mib_start;
    logic        o_mib_rd_wr_n;
    logic [15:0] o_dabus;
    logic        o_dabus_oe;
    logic [15:0] i_dabus;
    logic [7:0]  i_mib_slave_ack;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_status;
    logic [7:0]  o_rsp_ack_mask;

    always #5 CLK = ~CLK;

    mib_master_hub dut (
        .CLK             (CLK),
        .i_srst          (i_srst),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_rd_wr_n   (i_req_rd_wr_n),
        .i_req_addr      (i_req_addr),
        .i_req_wdata     (i_req_wdata),
        .i_slave_en      (i_slave_en),
        .o_mib_start     (o_mib_start),
        .o_mib_rd_wr_n   (o_mib_rd_wr_n),
        .o_dabus         (o_dabus),
        .o_dabus_oe      (o_dabus_oe),
        .i_dabus         (i_dabus),
        .i_mib_slave_ack (i_mib_slave_ack),
        .o_rsp_valid     (o_rsp_valid),
        .o_rsp_rdata     (o_rsp_rdata),
        .o_rsp_status    (o_rsp_status),
        .o_rsp_ack_mask  (o_rsp_ack_mask)
    );

    typedef struct packed {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  en;
        logic [7:0]  ack;
        int          k;      // ack cycle relative to WAIT_ACK entry
        logic [15:0] d0;
        logic [15:0] d1;
        bit          spur;   // also pulse the ack during the first address beat
        logic [1:0]  st;
        logic [31:0] rdata;
        logic [7:0]  mask;
        int          lat;    // accept cycle to rsp_valid cycle
    } vec_t;

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] rdata;
        logic [7:0]  mask;
    } rsp_t;

    localparam int NV = 9;
    vec_t vecs [NV];
    rsp_t sb_q [$];
    rsp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   waits;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest outstanding request
    always @(negedge CLK) begin
        if (o_rsp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_status", 64'(o_rsp_status), 64'(mon_e.st));
                chk("rsp_rdata", 64'(o_rsp_rdata), 64'(mon_e.rdata));
                chk("rsp_ack_mask", 64'(o_rsp_ack_mask), 64'(mon_e.mask));
            end
        end
    end

    // Drive one request and play the slave side; returns on the rsp_valid cycle
    task automatic run(input vec_t v, input bit hold, output int nwait);
        int   cyc;
        int   entry;
        int   ackc;
        bit   done;
        logic [15:0] beat;
        i_req_valid   = 1'b1;
        i_req_rd_wr_n = v.rd;
        i_req_addr    = v.addr;
        i_req_wdata   = v.wdata;
        i_slave_en    = v.en;
        nwait = 0;
        while (!o_req_ready && nwait < 100) begin
            @(negedge CLK);
            nwait++;
        end
        chk("req_ready_wait", 64'(o_req_ready), 64'(1));
        if (!o_req_ready) return;
        sb_q.push_back('{v.st, v.rdata, v.mask});
        entry = v.rd ? 3 : 5;
        ackc  = entry + v.k;
        cyc   = 0;
        done  = 0;
        while (!done && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            if (!hold) i_req_valid = 1'b0;
            if (o_rsp_valid) begin
                done = 1;
                chk("rsp_latency", 64'(cyc), 64'(v.lat));
            end else if (cyc <= 2 || (!v.rd && cyc <= 4)) begin
                case (cyc)
                    1:       beat = v.addr[31:16];
                    2:       beat = v.addr[15:0];
                    3:       beat = v.wdata[31:16];
                    default: beat = v.wdata[15:0];
                endcase
                chk("bus_beat", 64'({o_dabus_oe, o_mib_start, o_mib_rd_wr_n, o_req_ready, o_dabus}),
                    64'({1'b1, (cyc == 1), v.rd, 1'b0, beat}));
            end else begin
                chk("bus_quiet", 64'({o_dabus_oe, o_mib_start, o_mib_rd_wr_n, o_req_ready}),
                    64'({1'b0, 1'b0, v.rd, 1'b0}));
            end
            i_mib_slave_ack = ((cyc == ackc) || (v.spur && cyc == 1)) ? v.ack : 8'h00;
            if (v.rd && cyc == ackc + 1)      i_dabus = v.d0;
            else if (v.rd && cyc == ackc + 2) i_dabus = v.d1;
            else                              i_dabus = 16'($urandom);
        end
        if (!done) chk("rsp_seen", 64'(0), 64'(1));
        i_mib_slave_ack = 8'h00;
        $display("txn rd=%0d addr=%h lat=%0d status=%0d rdata=%h mask=%h",
                 v.rd, v.addr, cyc, o_rsp_status, o_rsp_rdata, o_rsp_ack_mask);
    endtask

    initial begin
        //                 rd    addr          wdata         en     ack    k    d0       d1       sp    st     rdata         mask   lat
        vecs[0] = '{1'b0, 32'h0123_4567, 32'hDEAD_BEEF, 8'hFF, 8'h08, 5,   16'h0,   16'h0,   1'b0, 2'b00, 32'h0,        8'h08, 11};
        vecs[1] = '{1'b1, 32'hA5A5_0001, 32'h0,         8'hFF, 8'h01, 0,   16'hCAFE, 16'hF00D, 1'b0, 2'b00, 32'hCAFE_F00D, 8'h01, 6};
        vecs[2] = '{1'b1, 32'h0000_0042, 32'h0,         8'hFF, 8'h00, 999, 16'h0,   16'h0,   1'b0, 2'b01, 32'h0,        8'h00, 67};
        vecs[3] = '{1'b1, 32'h0000_0043, 32'h0,         8'hFF, 8'h80, 63,  16'h1234, 16'h5678, 1'b0, 2'b00, 32'h1234_5678, 8'h80, 69};
        vecs[4] = '{1'b0, 32'h5555_AAAA, 32'h0F0F_F0F0, 8'hFF, 8'h22, 2,   16'h0,   16'h0,   1'b0, 2'b10, 32'h0,        8'h22, 8};
        vecs[5] = '{1'b0, 32'h5555_AAAA, 32'h0F0F_F0F0, 8'hDF, 8'h22, 2,   16'h0,   16'h0,   1'b0, 2'b00, 32'h0,        8'h02, 8};
        vecs[6] = '{1'b1, 32'h7777_0006, 32'h0,         8'hFF, 8'h22, 1,   16'h9999, 16'h8888, 1'b0, 2'b10, 32'h0,        8'h22, 5};
        vecs[7] = '{1'b1, 32'h7777_0007, 32'h0,         8'hFF, 8'h10, 3,   16'h0BAD, 16'hBEEF, 1'b1, 2'b00, 32'h0BAD_BEEF, 8'h10, 9};
        vecs[8] = '{1'b0, 32'h3333_0008, 32'h1357_2468, 8'hFE, 8'h01, 0,   16'h0,   16'h0,   1'b0, 2'b01, 32'h0,        8'h00, 69};

        i_srst          = 1'b1;
        i_req_valid     = 1'b0;
        i_req_rd_wr_n   = 1'b0;
        i_req_addr      = '0;
        i_req_wdata     = '0;
        i_slave_en      = 8'hFF;
        i_dabus         = '0;
        i_mib_slave_ack = '0;

        // Reset values, then ready one cycle after release
        repeat (3) @(negedge CLK);
        chk("reset_ctrl", 64'({o_req_ready, o_mib_start, o_mib_rd_wr_n, o_dabus_oe, o_rsp_valid, o_rsp_status}),
            64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00}));
        chk("reset_data", 64'({o_dabus, o_rsp_rdata, o_rsp_ack_mask}), 64'(0));
        i_srst = 1'b0;
        @(negedge CLK);
        chk("ready_after_reset", 64'(o_req_ready), 64'(1));

        for (int i = 0; i < NV; i++) run(vecs[i], 1'b0, waits);

        // Reset during WDATA: abort, no response, then a normal transaction
        i_req_valid   = 1'b1;
        i_req_rd_wr_n = 1'b0;
        i_req_addr    = 32'h1111_2222;
        i_req_wdata   = 32'h3333_4444;
        i_slave_en    = 8'hFF;
        waits = 0;
        while (!o_req_ready && waits < 100) begin
            @(negedge CLK);
            waits++;
        end
        repeat (3) begin
            @(negedge CLK);
            i_req_valid = 1'b0;
        end
        chk("wdata_before_reset", 64'({o_dabus_oe, o_dabus}), 64'({1'b1, 16'h3333}));
        i_srst = 1'b1;
        @(negedge CLK);
        chk("abort_outputs", 64'({o_dabus_oe, o_req_ready, o_rsp_valid}), 64'(0));
        i_srst = 1'b0;
        @(negedge CLK);
        chk("ready_after_abort", 64'(o_req_ready), 64'(1));
        repeat (2) @(negedge CLK);
        run(vecs[0], 1'b0, waits);

        // Back-to-back with valid held high: second accepted only once IDLE returns
        run(vecs[1], 1'b1, waits);
        run(vecs[5], 1'b0, waits);
        chk("b2b_gap", 64'(waits), 64'(1));
        repeat (2) @(negedge CLK);
        chk("rsp_hold", 64'({o_rsp_valid, o_rsp_status, o_rsp_ack_mask}), 64'({1'b0, 2'b00, 8'h02}));

        repeat (2) @(negedge CLK);
        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mib_master_hub.md
Name: mib_master_hub

Overview:
- Parametrised MIB bus master that replaces the single hard-wired start/rd_wr_n/slave_ack triple with a sequenced transaction engine.
- Accepts one read or write request at a time from the FMC-side command logic in cscfg.
- Serialises the address and write data onto the MIB data bus, then waits for slave acknowledges on a NUM_SLAVES-wide vector.
- Detects ack timeout and multi-slave ack collisions, and returns read data plus status on a response strobe.

Parameters:
- P_NUM_SLAVES, 8, number of per-slave ack inputs; range 1..16.
- P_DATA_W, 16, MIB data bus width.
- P_ADDR_BEATS, 2, address beats per transaction; address width = P_ADDR_BEATS*P_DATA_W.
- P_DATA_BEATS, 2, data beats per transaction; data width = P_DATA_BEATS*P_DATA_W.
- P_ACK_TIMEOUT_CLKS, 64, WAIT_ACK cycles before a timeout is declared; must be ≥2.

Ports:
- CLK  in  1  system clock.
- i_srst  in  1  reset, synchronous to CLK, active-high.
- i_req_valid  in  1  request strobe; accepted when o_req_ready=1.
- o_req_ready  out  1  high only in IDLE.
- i_req_rd_wr_n  in  1  1=read, 0=write.
- i_req_addr  in  P_ADDR_BEATS*P_DATA_W  target address.
- i_req_wdata  in  P_DATA_BEATS*P_DATA_W  write data.
- i_slave_en  in  P_NUM_SLAVES  ack enable mask; acks from disabled slaves are ignored.
- o_mib_start  out  1  pulse on the first address beat.
- o_mib_rd_wr_n  out  1  transaction direction, held for the whole transaction.
- o_dabus  out  P_DATA_W  bus drive value.
- o_dabus_oe  out  1  bus output enable; the top level builds the tristate.
- i_dabus  in  P_DATA_W  bus sample.
- i_mib_slave_ack  in  P_NUM_SLAVES  per-slave ack.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  P_DATA_BEATS*P_DATA_W  read data; 0 for writes and for errors.
- o_rsp_status  out  2  00=OK, 01=TIMEOUT, 10=COLLISION.
- o_rsp_ack_mask  out  P_NUM_SLAVES  masked ack vector captured at the first ack cycle.

Behaviour:
- Reset values: o_req_ready=1 one cycle after reset deasserts, 0 during reset. o_mib_start=0, o_mib_rd_wr_n=1, o_dabus=0, o_dabus_oe=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_status=0, o_rsp_ack_mask=0. State=IDLE.
- Reset mid-transaction: abort at the next edge, no o_rsp_valid for the aborted request, o_dabus_oe drops at the same edge.
- All outputs are registered.
- IDLE:
  - On i_req_valid&o_req_ready, latch addr/wdata/rd_wr_n and go to ADDR.
  - o_mib_rd_wr_n takes the latched value from the ADDR entry until DONE exits; it is 1 otherwise.
- ADDR:
  - Runs P_ADDR_BEATS cycles with o_dabus_oe=1 and the address driven most-significant beat first.
  - o_mib_start=1 on beat 0 only.
  - Write → WDATA; read → WAIT_ACK.
- WDATA: P_DATA_BEATS cycles, oe=1, wdata driven MS beat first, then → WAIT_ACK.
- WAIT_ACK:
  - oe=0. Counter starts at 0 on entry. Compute masked = i_mib_slave_ack & i_slave_en each cycle.
  - masked≠0: capture it into o_rsp_ack_mask. Popcount>1 → status COLLISION → DONE. Else write → DONE (OK); read → RDATA.
  - Counter reaches P_ACK_TIMEOUT_CLKS-1 with masked=0 → status TIMEOUT, ack_mask=0 → DONE.
  - An ack arriving on the final timeout cycle wins: OK, not TIMEOUT.
- RDATA: sample i_dabus on P_DATA_BEATS consecutive cycles starting the cycle after the ack, assembled MS beat first, then → DONE.
- DONE:
  - o_rsp_valid=1 for exactly one cycle, with rdata/status/ack_mask valid that cycle.
  - Next state is IDLE; o_req_ready rises the cycle after.
  - Status/rdata/ack_mask hold until the next DONE.
- Latency, request accept to rsp_valid, with ack k cycles after WAIT_ACK entry (k≥0):
  - Write: P_ADDR_BEATS + P_DATA_BEATS + k + 2.
  - Read: P_ADDR_BEATS + k + P_DATA_BEATS + 2.
- Requests presented while not ready are ignored; no queuing.
- Acks in any state other than WAIT_ACK are ignored.

Decomposition:
- Shared package mib_pkg: status enum (MIB_OK, MIB_TIMEOUT, MIB_COLLISION), state enum, P_DATA_W default constant.
- One sub-module, mib_ack_check: combinational masking/popcount>1/any-ack of the ack vector, reusable on the slave side.

Test Plan:
- Write 0x0123_4567 / wdata 0xDEAD_BEEF, slave 3 acks 5 cycles into WAIT_ACK → beats 0x0123, 0x4567, 0xDEAD, 0xBEEF. Start high on the first beat only. rsp_valid 11 cycles after accept, status 00, ack_mask 0x08.
- Read, slave 0 acks at k=0, then drives 0xCAFE, 0xF00D → rdata 0xCAFEF00D, status 00, oe=0 from WAIT_ACK onward.
- Read with no ack → status 01 exactly at counter 63, rdata 0, ack_mask 0. Separately, ack on cycle 63 → status 00.
- Slaves 1 and 5 ack in the same cycle → status 10, ack_mask 0x22. Then set i_slave_en=0xDF and repeat → status 00, ack_mask 0x02.
- Assert i_srst during WDATA → oe=0 and req_ready=0 next edge, no rsp_valid. The next request completes normally.
- Back-to-back i_req_valid held high → second request accepted only in IDLE after DONE; both responses correct.
